topk_merge_alu: RTL

//  Streaming top-K sort/merge unit for the k-NN/k-means datapath. It collects a K-entry

---
 rtl/topk_merge_alu.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/topk_merge_alu.sv
// topk_merge_alu: streaming top-K list merge/pass unit with a scalar COLLECT packer.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready/op/desc   command handshake (00 PASS, 01 MERGE, 10 COLLECT, 11 CLEAR)
//   in_valid/in_ready/in_data     list beats (data words 0..K-1, index words K..2K-1)
//   scl_valid/scl_ready/scl_data  scalar words for COLLECT
//   flush                         COLLECT: emit the partial beat and finish
//   out_valid/out_ready/out_data  result beats, out_cnt valid lanes, out_last final beat
module topk_merge_alu #(
    parameter int K     = 20,
    parameter int LANES = 16,
    parameter int DW    = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic                         cmd_desc,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*DW-1:0]          in_data,
    input  logic                         scl_valid,
    output logic                         scl_ready,
    input  logic [DW-1:0]                scl_data,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*DW-1:0]          out_data,
    output logic [$clog2(LANES+1)-1:0]   out_cnt,
    output logic                         out_last
);
    localparam int NB = (2 * K + LANES - 1) / LANES;
    localparam int NW = NB * LANES;
    localparam int AW = $clog2(NW);
    localparam int PW = $clog2(K + 1);
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW = $clog2(LANES + 1);
    localparam int LW = $clog2(LANES);
    localparam logic [CW-1:0] LAST_CNT = CW'(2 * K - (NB - 1) * LANES);
    localparam logic [1:0] OP_PASS  = 2'b00;
    localparam logic [1:0] OP_MERGE = 2'b01;
    localparam logic [1:0] OP_COLL  = 2'b10;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LNEW  = 3'd1;
    localparam logic [2:0] S_LOLD  = 3'd2;
    localparam logic [2:0] S_MERGE = 3'd3;
    localparam logic [2:0] S_EMIT  = 3'd4;
    localparam logic [2:0] S_COLL  = 3'd5;
    localparam logic [2:0] S_CLR   = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [1:0]    op_q;
    logic          desc_q;
    logic [DW-1:0] new_q [NW];
    logic [DW-1:0] old_q [NW];
    logic [DW-1:0] res_q [NW];
    logic [DW-1:0] cb_q  [LANES];
    logic [BW-1:0] beat_q;
    logic [PW-1:0] pn_q, po_q, m_q;
    logic [CW-1:0] cc_q, n_words;
    logic          pv_q, pl_q, fl_q;
    logic [AW-1:0] wa [LANES];
    logic [DW-1:0] hn, hni, ho, hoi;
    logic          beat_last, in_fire, take_old, fl_now, full, m_last;

    assign beat_last = beat_q == BW'(NB - 1);
    assign cmd_ready = state_q == S_IDLE;
    assign in_ready  = state_q == S_LNEW || state_q == S_LOLD;
    assign in_fire   = in_valid && in_ready;
    assign scl_ready = state_q == S_COLL && !pv_q;
    assign out_valid = state_q == S_EMIT || (state_q == S_COLL && pv_q);
    assign out_cnt   = state_q == S_EMIT ? (beat_last ? LAST_CNT : CW'(LANES)) : (out_valid ? cc_q : '0);
    assign out_last  = state_q == S_EMIT ? beat_last : out_valid && pl_q;

    // Heads of both lists; an index word sits K words after its data word.
    assign hn  = new_q[AW'(pn_q)];
    assign hni = new_q[AW'(K) + AW'(pn_q)];
    assign ho  = old_q[AW'(po_q)];
    assign hoi = old_q[AW'(K) + AW'(po_q)];
    // Old list wins ties so the running best list stays stable.
    assign take_old = pn_q == PW'(K) || (po_q != PW'(K) && (desc_q ? ho >= hn : ho <= hn));
    assign m_last   = m_q == PW'(K - 1);

    assign n_words = cc_q + CW'(scl_valid);
    assign full    = n_words == CW'(LANES);
    assign fl_now  = flush || fl_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign wa[l] = AW'(beat_q) * AW'(LANES) + AW'(l);
        assign out_data[l*DW +: DW] = state_q == S_EMIT ? (int'(wa[l]) < 2 * K ? res_q[wa[l]] : '0)
                                                        : (out_valid && l < int'(cc_q) ? cb_q[l] : '0);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_valid) state_d = cmd_op == OP_COLL ? S_COLL : cmd_op == OP_PASS || cmd_op == OP_MERGE ? S_LNEW : S_CLR;
            S_LNEW:  if (in_fire && beat_last) state_d = op_q == OP_MERGE ? S_LOLD : S_EMIT;
            S_LOLD:  if (in_fire && beat_last) state_d = S_MERGE;
            S_MERGE: if (m_last) state_d = S_EMIT;
            S_EMIT:  if (out_ready && beat_last) state_d = S_IDLE;
            S_COLL:  state_d = pv_q ? (out_ready && pl_q ? S_IDLE : S_COLL)
                                    : (fl_now && !full && n_words == '0 ? S_IDLE : S_COLL);
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            desc_q  <= 1'b0;
            beat_q  <= '0;
            pn_q    <= '0;
            po_q    <= '0;
            m_q     <= '0;
            cc_q    <= '0;
            pv_q    <= 1'b0;
            pl_q    <= 1'b0;
            fl_q    <= 1'b0;
            for (int i = 0; i < NW; i++) begin
                new_q[i] <= '0;
                old_q[i] <= '0;
                res_q[i] <= '0;
            end
            for (int i = 0; i < LANES; i++) cb_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (cmd_valid && cmd_ready) begin
                op_q   <= cmd_op;
                desc_q <= cmd_desc;
            end
            if (in_fire || (state_q == S_EMIT && out_ready)) beat_q <= beat_last ? '0 : beat_q + BW'(1);
            if (in_fire) begin
                for (int l = 0; l < LANES; l++) begin
                    if (state_q == S_LNEW) new_q[wa[l]] <= in_data[l*DW +: DW];
                    else old_q[wa[l]] <= in_data[l*DW +: DW];
                    // PASS loads straight into the result so EMIT needs no copy step.
                    if (state_q == S_LNEW && op_q == OP_PASS) res_q[wa[l]] <= in_data[l*DW +: DW];
                end
            end
            if (state_q == S_MERGE) begin
                res_q[AW'(m_q)]          <= take_old ? ho : hn;
                res_q[AW'(K) + AW'(m_q)] <= take_old ? hoi : hni;
                pn_q <= m_last ? '0 : pn_q + PW'(!take_old);
                po_q <= m_last ? '0 : po_q + PW'(take_old);
                m_q  <= m_last ? '0 : m_q + PW'(1);
            end
            if (state_q == S_COLL) begin
                if (pv_q) begin
                    // A flush seen while a full beat waits is remembered until it drains.
                    if (flush && !pl_q) fl_q <= 1'b1;
                    if (out_ready) begin
                        pv_q <= 1'b0;
                        cc_q <= '0;
                    end
                end else begin
                    if (scl_valid) cb_q[cc_q[LW-1:0]] <= scl_data;
                    if (full || (fl_now && n_words != '0)) begin
                        pv_q <= 1'b1;
                        pl_q <= fl_now;
                    end
                    cc_q <= n_words;
                    if (fl_now) fl_q <= 1'b0;
                end
            end
            if (state_q == S_CLR) begin
                for (int i = 0; i < NW; i++) begin
                    new_q[i] <= '0;
                    old_q[i] <= '0;
                    res_q[i] <= '0;
                end
                for (int i = 0; i < LANES; i++) cb_q[i] <= '0;
                cc_q <= '0;
                pv_q <= 1'b0;
                pl_q <= 1'b0;
                fl_q <= 1'b0;
            end
        end
    end
endmodule
